// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin IF/DM arbiter and multi-cycle sequencer for the shared 512x8 RAM.
module mem_access_ctrl #(
   parameter int WAIT_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        IF_REQ,
   input  logic [8:0]  IF_ADDR,
   output logic        IF_ACK,
   output logic [31:0] IF_DATA,
   output logic        IF_FAULT,
   input  logic        DM_REQ,
   input  logic        DM_RW,
   input  logic [1:0]  DM_MAS,
   input  logic        DM_SIGNED,
   input  logic [8:0]  DM_ADDR,
   input  logic [31:0] DM_WDATA,
   output logic        DM_ACK,
   output logic [31:0] DM_RDATA,
   output logic        DM_FAULT,
   output logic        RAM_EN,
   output logic        RAM_RW,
   output logic [1:0]  RAM_MAS,
   output logic [8:0]  RAM_ADDR,
   output logic [31:0] RAM_WDATA,
   input  logic [31:0] RAM_RDATA,
   input  logic        RAM_DONE,
   output logic        BUSY
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [7:0] WAIT_M1  = 8'(WAIT_CYCLES - 1);
   localparam logic [7:0] TMO_M1   = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        gnt_dm_q;
   logic        rw_q, signed_q, fault_q;
   logic [1:0]  mas_q;
   logic [8:0]  addr_q;
   logic [31:0] wdata_q, if_data_q, dm_rdata_q;
   logic        req_any, pick_dm, misal, done_ok, tmo;
   logic [1:0]  sel_mas;
   logic [8:0]  sel_addr;
   logic [31:0] rd_fmt;

   // gnt_dm_q doubles as the last-grant marker for round-robin
   assign req_any  = IF_REQ | DM_REQ;
   assign pick_dm  = DM_REQ & (~IF_REQ | ~gnt_dm_q);
   assign sel_mas  = pick_dm ? DM_MAS : 2'b10;
   assign sel_addr = pick_dm ? DM_ADDR : IF_ADDR;
   assign misal    = (sel_mas == 2'b11) | (sel_mas == 2'b01 & sel_addr[0]) | (sel_mas == 2'b10 & |sel_addr[1:0]);
   assign done_ok  = (cnt_q >= WAIT_M1) & RAM_DONE;
   assign tmo      = cnt_q == TMO_M1;
   assign rd_fmt   = mas_q == 2'b00 ? {{24{signed_q & RAM_RDATA[7]}}, RAM_RDATA[7:0]} :
                     mas_q == 2'b01 ? {{16{signed_q & RAM_RDATA[15]}}, RAM_RDATA[15:0]} : RAM_RDATA;

   always_comb begin
      state_d = state_q;
      cnt_d   = 8'd0;
      if (state_q == S_IDLE && req_any) state_d = misal ? S_RESP : S_ACCESS;
      if (state_q == S_ACCESS) begin
         cnt_d   = cnt_q + 8'd1;
         state_d = (done_ok | tmo) ? S_RESP : S_ACCESS;
      end
      if (state_q == S_RESP) state_d = S_IDLE;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         gnt_dm_q   <= 1'b1;
         rw_q       <= 1'b0;
         signed_q   <= 1'b0;
         fault_q    <= 1'b0;
         mas_q      <= 2'b00;
         addr_q     <= 9'd0;
         wdata_q    <= 32'd0;
         if_data_q  <= 32'd0;
         dm_rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req_any) begin
            gnt_dm_q <= pick_dm;
            rw_q     <= pick_dm ? DM_RW : 1'b1;
            mas_q    <= sel_mas;
            signed_q <= pick_dm & DM_SIGNED;
            addr_q   <= sel_addr;
            wdata_q  <= pick_dm ? DM_WDATA : 32'd0;
            fault_q  <= misal;
         end
         // completion wins over timeout when both land on the same cycle
         if (state_q == S_ACCESS) begin
            if (done_ok) begin
               if (!gnt_dm_q) if_data_q <= RAM_RDATA;
               else if (rw_q) dm_rdata_q <= rd_fmt;
            end else if (tmo) fault_q <= 1'b1;
         end
      end
   end

   assign IF_ACK    = (state_q == S_RESP) & ~gnt_dm_q;
   assign DM_ACK    = (state_q == S_RESP) & gnt_dm_q;
   assign IF_FAULT  = IF_ACK & fault_q;
   assign DM_FAULT  = DM_ACK & fault_q;
   assign IF_DATA   = if_data_q;
   assign DM_RDATA  = dm_rdata_q;
   assign RAM_EN    = state_q == S_ACCESS;
   assign RAM_RW    = rw_q;
   assign RAM_MAS   = mas_q;
   assign RAM_ADDR  = addr_q;
   assign RAM_WDATA = wdata_q;
   assign BUSY      = state_q != S_IDLE;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven vectors with a scoreboard queue, plus reset and round-robin sequences.
module tb_mem_access_ctrl;
   logic        CLK = 1'b0, CLR = 1'b0;
   logic        IF_REQ = 1'b0, DM_REQ = 1'b0, DM_RW = 1'b0, DM_SIGNED = 1'b0, RAM_DONE = 1'b0;
   logic [8:0]  IF_ADDR = '0, DM_ADDR = '0;
   logic [1:0]  DM_MAS = '0;
   logic [31:0] DM_WDATA = '0, RAM_RDATA = '0;
   logic        IF_ACK, IF_FAULT, DM_ACK, DM_FAULT, RAM_EN, RAM_RW, BUSY;
   logic [31:0] IF_DATA, DM_RDATA, RAM_WDATA;
   logic [1:0]  RAM_MAS;
   logic [8:0]  RAM_ADDR;

   mem_access_ctrl #(.WAIT_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .CLR(CLR), .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_DATA(IF_DATA),
      .IF_FAULT(IF_FAULT), .DM_REQ(DM_REQ), .DM_RW(DM_RW), .DM_MAS(DM_MAS), .DM_SIGNED(DM_SIGNED),
      .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA), .DM_FAULT(DM_FAULT),
      .RAM_EN(RAM_EN), .RAM_RW(RAM_RW), .RAM_MAS(RAM_MAS), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
      .RAM_RDATA(RAM_RDATA), .RAM_DONE(RAM_DONE), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        dm;
      logic        rw;
      logic [1:0]  mas;
      logic        sgn;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        done;
      logic        fault;
      int          lat;
   } vec_t;

   typedef struct {
      logic        dm;
      logic        fault;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[14];
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] m_if = '0, m_dm = '0;

   function automatic logic [31:0] fmt(input logic [1:0] mas, input logic sgn, input logic [31:0] rd);
      if (mas == 2'b00) return sgn && rd[7] ? {24'hFFFFFF, rd[7:0]} : {24'h0, rd[7:0]};
      if (mas == 2'b01) return sgn && rd[15] ? {16'hFFFF, rd[15:0]} : {16'h0, rd[15:0]};
      return rd;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_ack(input int n);
      exp_t e;
      if (sb.size() == 0) begin
         chk("unexpected_ack", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("ack_port", {30'd0, IF_ACK, DM_ACK}, {30'd0, ~e.dm, e.dm});
      chk("fault", {31'd0, e.dm ? DM_FAULT : IF_FAULT}, {31'd0, e.fault});
      chk("data", e.dm ? DM_RDATA : IF_DATA, e.data);
      chk("latency", n, e.lat);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      int   n, en;
      logic ram_ok, hit;
      e.dm    = v.dm;
      e.fault = v.fault;
      e.lat   = v.lat;
      if (v.fault || (v.dm && !v.rw)) e.data = v.dm ? m_dm : m_if;
      else e.data = v.dm ? fmt(v.mas, v.sgn, v.rdata) : v.rdata;
      if (v.dm) m_dm = e.data;
      else m_if = e.data;
      sb.push_back(e);
      @(negedge CLK);
      IF_REQ = ~v.dm; DM_REQ = v.dm; DM_RW = v.rw; DM_MAS = v.mas; DM_SIGNED = v.sgn;
      DM_ADDR = v.addr; IF_ADDR = v.addr; DM_WDATA = v.wdata; RAM_RDATA = v.rdata; RAM_DONE = v.done;
      n = 0; en = 0; ram_ok = 1'b1; hit = 1'b0;
      while (!hit && n < 40) begin
         n++;
         @(negedge CLK);
         if (RAM_EN) begin
            en++;
            if (RAM_ADDR !== v.addr || RAM_MAS !== (v.dm ? v.mas : 2'b10) || RAM_RW !== (v.dm ? v.rw : 1'b1) ||
                (v.dm && !v.rw && RAM_WDATA !== v.wdata)) ram_ok = 1'b0;
         end
         if (IF_ACK || DM_ACK) begin
            hit = 1'b1;
            IF_REQ = 1'b0; DM_REQ = 1'b0;
            check_ack(n);
         end
      end
      if (!hit) begin
         $display("FAIL ack_wait vec %0d: no ACK within %0d cycles", idx, n);
         n_cmp++; n_bad++;
         void'(sb.pop_front());
      end
      chk($sformatf("ram_en_cycles v%0d", idx), en, v.lat - 1);
      chk($sformatf("ram_fields v%0d", idx), {31'd0, ram_ok}, 32'd1);
      @(negedge CLK);
      chk("post_ack_idle", {30'd0, IF_ACK | DM_ACK, BUSY}, 32'd0);
   endtask

   initial begin
      int   n, acks, spacing_bad;
      logic leak;
      tbl[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 9'h004, 32'h0,        32'hE3A01005, 1'b1, 1'b0, 3};
      tbl[1]  = '{1'b1, 1'b0, 2'b01, 1'b0, 9'h010, 32'h0000BEEF, 32'h0,        1'b1, 1'b0, 3};
      tbl[2]  = '{1'b1, 1'b1, 2'b01, 1'b1, 9'h010, 32'h0,        32'h0000BEEF, 1'b1, 1'b0, 3};
      tbl[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 9'h010, 32'h0,        32'h0000BEEF, 1'b1, 1'b0, 3};
      tbl[4]  = '{1'b1, 1'b1, 2'b00, 1'b1, 9'h013, 32'h0,        32'h12345680, 1'b1, 1'b0, 3};
      tbl[5]  = '{1'b1, 1'b1, 2'b00, 1'b0, 9'h001, 32'h0,        32'h000000F0, 1'b1, 1'b0, 3};
      tbl[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 9'h1FC, 32'h0,        32'hCAFEBABE, 1'b1, 1'b0, 3};
      tbl[7]  = '{1'b1, 1'b1, 2'b10, 1'b0, 9'h012, 32'h0,        32'h11111111, 1'b1, 1'b1, 1};
      tbl[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 9'h000, 32'h0,        32'h22222222, 1'b1, 1'b1, 1};
      tbl[9]  = '{1'b1, 1'b1, 2'b01, 1'b1, 9'h011, 32'h0,        32'h33333333, 1'b1, 1'b1, 1};
      tbl[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 9'h002, 32'h0,        32'h44444444, 1'b1, 1'b1, 1};
      tbl[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0,        32'h55555555, 1'b0, 1'b1, 17};
      tbl[12] = '{1'b0, 1'b1, 2'b10, 1'b0, 9'h024, 32'h0,        32'h66666666, 1'b0, 1'b1, 17};
      tbl[13] = '{1'b1, 1'b0, 2'b00, 1'b0, 9'h1FF, 32'h000000AA, 32'h0,        1'b1, 1'b0, 3};

      #1 CLR = 1'b1;
      #1;
      chk("reset_outputs", {31'd0, |{IF_ACK, IF_DATA, IF_FAULT, DM_ACK, DM_RDATA, DM_FAULT, RAM_EN, RAM_RW,
                                      RAM_MAS, RAM_ADDR, RAM_WDATA, BUSY}}, 32'd0);
      @(negedge CLK);
      CLR = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

      // abort an IF access with CLR, then check IF wins the first tie afterwards
      @(negedge CLK);
      IF_REQ = 1'b1; IF_ADDR = 9'h00C; RAM_DONE = 1'b0;
      repeat (2) @(negedge CLK);
      chk("en_before_clr", {31'd0, RAM_EN}, 32'd1);
      CLR = 1'b1;
      #1;
      chk("clr_abort", {29'd0, RAM_EN, BUSY, IF_ACK}, 32'd0);
      chk("clr_if_data", IF_DATA, 32'd0);
      chk("clr_dm_rdata", DM_RDATA, 32'd0);
      m_if = '0; m_dm = '0;
      IF_REQ = 1'b0;
      @(negedge CLK);
      CLR = 1'b0;
      leak = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         leak = leak | IF_ACK | DM_ACK | BUSY;
      end
      chk("no_ack_after_clr", {31'd0, leak}, 32'd0);

      sb.push_back('{1'b0, 1'b0, 32'h11223344, 3});
      sb.push_back('{1'b1, 1'b0, 32'h11223344, 4});
      sb.push_back('{1'b0, 1'b0, 32'h11223344, 4});
      IF_REQ = 1'b1; DM_REQ = 1'b1; IF_ADDR = 9'h008; DM_ADDR = 9'h020; DM_RW = 1'b1;
      DM_MAS = 2'b10; DM_SIGNED = 1'b0; RAM_RDATA = 32'h11223344; RAM_DONE = 1'b1;
      n = 0; acks = 0; spacing_bad = 0;
      for (int c = 0; c < 40 && acks < 3; c++) begin
         @(negedge CLK);
         n++;
         if (IF_ACK || DM_ACK) begin
            acks++;
            if (acks == 3) begin IF_REQ = 1'b0; DM_REQ = 1'b0; end
            check_ack(n);
            n = 0;
         end
      end
      chk("rr_ack_count", acks, 3);
      while (sb.size() > 0) void'(sb.pop_front());
      @(negedge CLK);
      chk("rr_idle", {30'd0, IF_ACK | DM_ACK, BUSY}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
